// File: rtl/pz_pkg.sv
// pz_pkg: shared state encoding, sizes and LED constants for the PunchZombi round controller
package pz_pkg;
    localparam int HOLE_W    = 2;
    localparam int NUM_HOLES = 3;
    localparam int LED_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LATCH,
        S_SHOW,
        S_GAP,
        S_OVER
    } state_t;

    localparam logic [LED_W-1:0] LED_OFF  = 4'b0000;
    localparam logic [LED_W-1:0] LED_OVER = 4'b0001;

    function automatic logic [LED_W-1:0] hole_led(input logic [HOLE_W-1:0] h);
        return LED_W'(1) << h;
    endfunction
endpackage

// File: rtl/pz_edge_det.sv
// pz_edge_det: registered-history rising-edge detector, one bit per lane
module pz_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);
    logic [W-1:0] din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_q <= '0;
        else        din_q <= din;
    end

    assign rise = din & ~din_q;
endmodule

// File: rtl/zombie_round_ctrl.sv
// zombie_round_ctrl: requests a random hole, lights it, times the punch and scores hits/misses
module zombie_round_ctrl
    import pz_pkg::*;
#(
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 12_500_000,
    parameter int START_LIVES = 3,
    parameter int SCORE_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] btn,
    input  logic [HOLE_W-1:0]    rand_num,
    output logic                 generate_random,
    output logic [LED_W-1:0]     led,
    output logic [SCORE_W-1:0]   score,
    output logic [1:0]           lives,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 game_over
);
    localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [HOLE_W-1:0]    hole_q, hole_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [1:0]           lives_q, lives_d;
    logic                 hit_q, hit_d, miss_q, miss_d;
    logic [NUM_HOLES-1:0] press, hole_btn;
    logic                 start_rise, wrong, hit, miss;

    pz_edge_det #(.W(NUM_HOLES)) u_btn_edge (.clk(clk), .rst_n(rst_n), .din(btn), .rise(press));
    pz_edge_det #(.W(1)) u_start_edge (.clk(clk), .rst_n(rst_n), .din(start), .rise(start_rise));

    // A stray press on any other hole is a miss even if the right hole is punched too
    assign hole_btn = NUM_HOLES'(1) << (hole_q - HOLE_W'(1));
    assign wrong    = |(press & ~hole_btn);
    assign hit      = !wrong && |(press & hole_btn);
    assign miss     = wrong || (!hit && timer_q == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        hole_d  = hole_q;
        score_d = score_q;
        lives_d = lives_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    score_d = '0;
                    lives_d = 2'(START_LIVES);
                    state_d = S_REQ;
                end
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: state_d = S_LATCH;
            S_LATCH: begin
                if (rand_num == '0) begin
                    state_d = S_REQ;
                end else begin
                    hole_d  = rand_num;
                    timer_d = SHOW_LOAD;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                timer_d = timer_q - 1'b1;
                if (hit) begin
                    hit_d   = 1'b1;
                    score_d = &score_q ? score_q : score_q + 1'b1;
                    timer_d = GAP_LOAD;
                    state_d = S_GAP;
                end else if (miss) begin
                    miss_d  = 1'b1;
                    lives_d = lives_q - 2'd1;
                    timer_d = GAP_LOAD;
                    state_d = (lives_q == 2'd1) ? S_OVER : S_GAP;
                end
            end
            S_GAP: begin
                timer_d = timer_q - 1'b1;
                if (timer_q == '0) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            hole_q  <= '0;
            score_q <= '0;
            lives_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            hole_q  <= hole_d;
            score_q <= score_d;
            lives_q <= lives_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign generate_random = (state_q == S_REQ);
    assign game_over       = (state_q == S_OVER);
    assign led             = (state_q == S_SHOW) ? hole_led(hole_q) :
                             (state_q == S_OVER) ? LED_OVER : LED_OFF;
    assign score           = score_q;
    assign lives           = lives_q;
    assign hit_pulse       = hit_q;
    assign miss_pulse      = miss_q;
endmodule

// File: tb/tb_zombie_round_ctrl.sv
// tb_zombie_round_ctrl: scoreboard bench driving random rounds against a game-rule model
module tb_zombie_round_ctrl;
    localparam int SHOW  = 8;
    localparam int GAP   = 4;
    localparam int LIVES = 3;
    localparam int SW    = 3;
    localparam int SMAX  = (1 << SW) - 1;
    localparam int A_HIT = 0, A_WRONG = 1, A_BOTH = 2, A_TIME = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    btn = 3'b000;
    logic [1:0]    rand_num = 2'd0;
    logic          generate_random, hit_pulse, miss_pulse, game_over;
    logic [3:0]    led;
    logic [SW-1:0] score;
    logic [1:0]    lives;

    int checks = 0, failures = 0, score_m = 0, lives_m = 0;
    bit over_m = 1'b0;

    typedef struct {
        bit hit;
        int score;
        int lives;
        int led;
        bit over;
    } exp_t;
    exp_t sb[$];

    zombie_round_ctrl #(
        .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .START_LIVES(LIVES), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .rand_num(rand_num),
        .generate_random(generate_random), .led(led), .score(score), .lives(lives),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, "_led"}, led, 0);
        check({name, "_score"}, score, 0);
        check({name, "_lives"}, lives, 0);
        check({name, "_pulses"}, {hit_pulse, miss_pulse}, 0);
        check({name, "_gen"}, generate_random, 0);
        check({name, "_over"}, game_over, 0);
    endtask

    task automatic start_game();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        score_m = 0;
        lives_m = LIVES;
        over_m  = 1'b0;
        check("start_req", generate_random, 1);
        check("start_score", score, 0);
        check("start_lives", lives, LIVES);
        check("start_over", game_over, 0);
    endtask

    task automatic wait_req(input bit noise);
        int n = 0;
        while (!generate_random && n < 50) begin
            if (noise) begin
                btn   = 3'($urandom);
                start = 1'($urandom);
            end
            step();
            n++;
        end
        check("gap_len", n, GAP);
    endtask

    // Entered at a negedge where the request pulse is visible; returns at the next one, or in OVER
    task automatic play_round(input logic [1:0] rn, input int act, input int d, input bit held, input bit keep);
        logic [2:0] hb, pv, w;
        exp_t e;
        rand_num = rn;
        start = 1'b0;
        if (!held) btn = 3'b000;
        step();
        check("req_width", generate_random, 0);
        step();
        check("latch_led", led, 0);
        step();
        if (rn == 2'd0) begin
            check("rereq_pulse", generate_random, 1);
            check("rereq_led", led, 0);
            return;
        end
        check("show_led", led, 1 << rn);
        hb = 3'(1 << (int'(rn) - 1));
        w = 3'b000;
        while (w == 3'b000) w = 3'($urandom_range(1, 7)) & ~hb;
        pv = (act == A_HIT) ? hb : (act == A_WRONG) ? w : (act == A_BOTH) ? (w | hb) : 3'b000;
        if (held || act == A_TIME) begin
            pv = 3'b000;
            d = SHOW;
        end
        e.hit = (pv != 3'b000) && ((pv & ~hb) == 3'b000);
        if (e.hit) score_m = (score_m < SMAX) ? score_m + 1 : SMAX;
        else lives_m--;
        over_m  = (lives_m == 0);
        e.score = score_m;
        e.lives = lives_m;
        e.led   = over_m ? 1 : 0;
        e.over  = over_m;
        sb.push_back(e);
        for (int s = 1; s < d; s++) begin
            step();
            check("show_lit", led, 1 << rn);
        end
        if (pv != 3'b000) btn = pv;
        step();
        if (!keep) btn = 3'b000;
        if (over_m) begin
            for (int i = 0; i < 3; i++) begin
                step();
                check("over_led", led, 1);
                check("over_flag", game_over, 1);
                check("over_no_req", generate_random, 0);
                check("over_score", score, score_m);
                check("over_lives", lives, 0);
            end
        end else begin
            wait_req(!keep);
        end
    endtask

    task automatic reset_mid();
        rand_num = 2'd1;
        start = 1'b0;
        btn = 3'b000;
        step();
        step();
        step();
        check("pre_reset_led", led, 4'b0010);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        sb.delete();
        over_m = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_zero("post_rst");
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (hit_pulse || miss_pulse)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse hit=%0d miss=%0d expected no pulse", hit_pulse, miss_pulse);
            end else begin
                e = sb.pop_front();
                check("pulse_hit", hit_pulse, e.hit);
                check("pulse_miss", miss_pulse, !e.hit);
                check("pulse_score", score, e.score);
                check("pulse_lives", lives, e.lives);
                check("pulse_led", led, e.led);
                check("pulse_over", game_over, e.over);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        check_zero("idle");
        start_game();
        play_round(2'd2, A_HIT, 3, 1'b0, 1'b0);
        play_round(2'd1, A_TIME, 1, 1'b0, 1'b0);
        play_round(2'd3, A_WRONG, 2, 1'b0, 1'b0);
        play_round(2'd2, A_HIT, SHOW, 1'b0, 1'b0);
        play_round(2'd2, A_HIT, 2, 1'b0, 1'b1);
        play_round(2'd2, A_TIME, 1, 1'b1, 1'b0);
        start_game();
        play_round(2'd1, A_BOTH, 4, 1'b0, 1'b0);
        play_round(2'd0, A_HIT, 1, 1'b0, 1'b0);
        play_round(2'd3, A_HIT, 1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            play_round(2'($urandom_range(1, 3)), A_HIT, $urandom_range(1, SHOW), 1'b0, 1'b0);
        check("saturated", score, SMAX);
        reset_mid();
        start_game();
        for (int i = 0; i < 60; i++) begin
            if (over_m) start_game();
            play_round(2'($urandom_range(0, 3)),
                       ($urandom_range(0, 9) < 6) ? A_HIT : $urandom_range(1, 3),
                       $urandom_range(1, SHOW), 1'b0, 1'b0);
        end
        step();
        step();
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/zombie_round_ctrl.md
Name: zombie_round_ctrl

Overview:
- Game-round controller directly downstream of the 2-bit LFSR random generator in PunchZombi.
- Requests a value with a one-cycle generate_random pulse and consumes rand_num (1..3) to pick which zombie hole lights.
- Times the player's punch, then scores a hit or charges a miss/life.
- Drives the hole LEDs and the score/lives outputs consumed by the display logic.

Parameters:
- SHOW_CYCLES, 50_000_000: clock cycles a zombie stays lit before a timeout miss (minimum 2).
- GAP_CYCLES, 12_500_000: blank cycles between zombies (minimum 1).
- START_LIVES, 3: lives loaded at game start (1..3).
- SCORE_W, 8: score width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; rising edge starts or restarts a game from IDLE or OVER.
- btn  in  3  debounced, synchronised punch buttons, active-high level; btn[k-1] hits hole k.
- rand_num  in  2  random hole from the generator, registered there, valid 1..3.
- generate_random  out  1  one-cycle request pulse to the generator.
- led  out  4  led[k] lit = zombie in hole k (k=1..3); led[0] = game-over lamp.
- score  out  SCORE_W  hits this game, saturating.
- lives  out  2  remaining lives.
- hit_pulse  out  1  one-cycle pulse per scored hit.
- miss_pulse  out  1  one-cycle pulse per miss.
- game_over  out  1  high in OVER.

Behaviour:
- Reset (rst_n low, async): state IDLE, all outputs 0, timer 0, button-edge history 0, start history 0.
- Edge detect:
  - Registered copies of btn and start.
  - press[k] = btn[k] & ~btn_d[k].
  - Only rising edges count; a held button never re-triggers.
- FSM states: IDLE, REQ, WAIT, LATCH, SHOW, GAP, OVER.
- IDLE: on start rising edge, score<=0, lives<=START_LIVES, go REQ.
- REQ: generate_random=1 for exactly this cycle, go WAIT.
  - The generator updates rand_num on the edge that samples the request.
- WAIT: one cycle for rand_num to settle, go LATCH.
- LATCH: sample rand_num into hole register.
  - If rand_num==0, discard it and go REQ (re-request).
  - Otherwise timer<=SHOW_CYCLES-1, go SHOW.
- SHOW:
  - led[hole]=1 and other LEDs 0.
  - Timer decrements by 1 each cycle.
  - Checks run in priority order, all in the same cycle:
    1. Any press on a non-hole button in this cycle: miss, even if the correct button is also pressed.
    2. Else press on the hole button: hit. Score+1, saturating at all-ones; hit_pulse=1.
    3. Else timer==0: miss.
  - A correct press in the timer==0 cycle is a hit.
  - Miss: miss_pulse=1, lives-1.
  - Either outcome clears the LEDs next cycle.
  - If a miss makes lives 0, go OVER; otherwise timer<=GAP_CYCLES-1 and go GAP.
- GAP:
  - LEDs off; presses ignored, no score or pulses.
  - Count down; at timer==0 go REQ.
- OVER:
  - game_over=1, led=4'b0001; score and lives held.
  - On start rising edge, reinitialise as in IDLE and go REQ.
- start edge outside IDLE/OVER is ignored.
- Reset mid-round: immediate return to the reset state; no pulses emitted.
- Latency from entering REQ to the LED lighting is 3 cycles (REQ, WAIT, LATCH).
- Timer width: $clog2(max(SHOW_CYCLES,GAP_CYCLES)).
- hit_pulse and miss_pulse are mutually exclusive and registered.

Decomposition:
- Shared package pz_pkg:
  - FSM state enum.
  - HOLE_W=2, NUM_HOLES=3, LED_W=4.
  - LED one-hot encoding constants.
- One sub-module, pz_edge_det: parameterised-width rising-edge detector.
  - Instantiated for btn (width 3) and start (width 1).

Test Plan:
- Reset and latency:
  - Stimulus: SHOW_CYCLES=8, GAP_CYCLES=4; release rst_n, pulse start; generator model returns rand_num=2.
  - Required: generate_random high exactly 1 cycle; led=4'b0100 three cycles after REQ entry.
- Correct hit:
  - Stimulus: hole 2 lit; btn=3'b010 on cycle 3 of SHOW.
  - Required: hit_pulse one cycle, score=1, lives=3, led=0 next cycle, REQ again after 4 GAP cycles.
- Timeout and wrong button:
  - Stimulus: hole 1 lit with no press; next round, hole 3 lit and btn=3'b001 pressed.
  - Required: two miss_pulses, lives 3->2->1, score unchanged.
- Simultaneous and boundary presses:
  - Stimulus: btn=3'b011 with hole 1 lit.
  - Required: miss.
  - Stimulus: correct press exactly on the timer==0 cycle.
  - Required: hit.
  - Stimulus: held button across rounds.
  - Required: no second hit.
- Game over and restart:
  - Stimulus: START_LIVES=1; one miss, then start rising edge.
  - Required: game_over=1, led=4'b0001, score held; then score=0, lives=1, new REQ pulse.
- Invalid value and async reset:
  - Stimulus: generator model returns rand_num=0.
  - Required: second generate_random pulse with no LED lit.
  - Stimulus: assert rst_n low mid-SHOW.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
